// File: rtl/mrm_unidade_controle_if.sv
// rtl/mrm_unidade_controle_if.sv - control/status bundle between the game controller and its datapath
//
// Inputs to the controller (driven by datapath / player side):
//   iniciar, jogada_pulso, igual, fimJ, fimL, fimP
// Outputs from the controller:
//   counter controls zeraJ/contaJ, zeraL/contaL, zeraP/contaP;
//   strobes gera_rand, escreve_ram, registra_jogada, habilita_comp,
//   show_display, reset_display; address select sel_endereco;
//   status pronto, ganhou, perdeu, timeout; debug db_estado[3:0].
// modport master = controller side, modport slave = datapath side.
interface mrm_unidade_controle_if;
    logic       iniciar;
    logic       jogada_pulso;
    logic       igual;
    logic       fimJ;
    logic       fimL;
    logic       fimP;

    logic       zeraJ;
    logic       contaJ;
    logic       zeraL;
    logic       contaL;
    logic       zeraP;
    logic       contaP;
    logic       gera_rand;
    logic       escreve_ram;
    logic       registra_jogada;
    logic       sel_endereco;
    logic       habilita_comp;
    logic       show_display;
    logic       reset_display;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada_pulso, igual, fimJ, fimL, fimP,
        output zeraJ, contaJ, zeraL, contaL, zeraP, contaP,
        output gera_rand, escreve_ram, registra_jogada, sel_endereco,
        output habilita_comp, show_display, reset_display,
        output pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_pulso, igual, fimJ, fimL, fimP,
        input  zeraJ, contaJ, zeraL, contaL, zeraP, contaP,
        input  gera_rand, escreve_ram, registra_jogada, sel_endereco,
        input  habilita_comp, show_display, reset_display,
        input  pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/mrm_unidade_controle.sv
// rtl/mrm_unidade_controle.sv - Moore control FSM for the memory game (show sequence, collect moves, win/lose/timeout)
//
// Parameter: TIMEOUT_CICLOS - clock cycles allowed per player move.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   ctl   - mrm_unidade_controle_if.master: datapath flags in, counter
//           controls / strobes / status / db_estado out.
module mrm_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                   clock,
    input  logic                   reset,
    mrm_unidade_controle_if.master ctl
);

    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_gera           = 4'h2,
        st_escreve        = 4'h3,
        st_mostra         = 4'h4,
        st_avanca_mostra  = 4'h5,
        st_zera_espera    = 4'h6,
        st_espera         = 4'h7,
        st_registra       = 4'h8,
        st_compara        = 4'h9,
        st_avanca_espera  = 4'hA,
        st_proxima_rodada = 4'hB,
        st_ganhou         = 4'hC,
        st_perdeu         = 4'hD,
        st_timeout        = 4'hE,
        st_invalido       = 4'hF
    } estado_t;

    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

    estado_t          estado;
    estado_t          proximo;
    logic [CNT_W-1:0] cnt_timeout;
    logic             expirou;

    assign expirou = (cnt_timeout == CNT_LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= st_inicial;
        end else begin
            estado <= proximo;
        end
    end

    // The counter follows the next state so it reads 0 in every state except
    // espera, and inside espera equals the cycles already spent there. It
    // never passes CNT_LIMITE because espera is left on that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_timeout <= '0;
        end else if (proximo == st_espera && estado == st_espera) begin
            cnt_timeout <= cnt_timeout + CNT_W'(1);
        end else begin
            cnt_timeout <= '0;
        end
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            st_inicial:        proximo = ctl.iniciar ? st_preparacao : st_inicial;
            st_preparacao:     proximo = st_gera;
            st_gera:           proximo = st_escreve;
            st_escreve:        proximo = st_mostra;
            st_mostra: begin
                if (ctl.fimP) begin
                    proximo = ctl.fimJ ? st_zera_espera : st_avanca_mostra;
                end
            end
            st_avanca_mostra:  proximo = st_mostra;
            st_zera_espera:    proximo = st_espera;
            st_espera: begin
                // A move arriving on the expiry cycle still counts.
                if (ctl.jogada_pulso) begin
                    proximo = st_registra;
                end else if (expirou) begin
                    proximo = st_timeout;
                end
            end
            st_registra:       proximo = st_compara;
            st_compara: begin
                if (!ctl.igual) begin
                    proximo = st_perdeu;
                end else if (!ctl.fimJ) begin
                    proximo = st_avanca_espera;
                end else if (!ctl.fimL) begin
                    proximo = st_proxima_rodada;
                end else begin
                    proximo = st_ganhou;
                end
            end
            st_avanca_espera:  proximo = st_espera;
            st_proxima_rodada: proximo = st_gera;
            st_ganhou, st_perdeu, st_timeout: begin
                if (ctl.iniciar) begin
                    proximo = st_preparacao;
                end
            end
            default:           proximo = st_inicial;
        endcase
    end

    always_comb begin
        ctl.zeraJ           = 1'b0;
        ctl.contaJ          = 1'b0;
        ctl.zeraL           = 1'b0;
        ctl.contaL          = 1'b0;
        ctl.zeraP           = 1'b0;
        ctl.contaP          = 1'b0;
        ctl.gera_rand       = 1'b0;
        ctl.escreve_ram     = 1'b0;
        ctl.registra_jogada = 1'b0;
        ctl.sel_endereco    = 1'b0;
        ctl.habilita_comp   = 1'b0;
        ctl.show_display    = 1'b0;
        ctl.reset_display   = 1'b0;
        ctl.pronto          = 1'b0;
        ctl.ganhou          = 1'b0;
        ctl.perdeu          = 1'b0;
        ctl.timeout         = 1'b0;
        ctl.db_estado       = estado;
        unique case (estado)
            st_preparacao: begin
                ctl.zeraJ         = 1'b1;
                ctl.zeraL         = 1'b1;
                ctl.zeraP         = 1'b1;
                ctl.reset_display = 1'b1;
            end
            st_gera:       ctl.gera_rand = 1'b1;
            st_escreve:    ctl.escreve_ram = 1'b1;
            st_mostra: begin
                ctl.show_display = 1'b1;
                ctl.contaP       = 1'b1;
                ctl.sel_endereco = 1'b1;
            end
            st_avanca_mostra: begin
                ctl.contaJ = 1'b1;
                ctl.zeraP  = 1'b1;
            end
            st_zera_espera: begin
                ctl.zeraJ         = 1'b1;
                ctl.zeraP         = 1'b1;
                ctl.reset_display = 1'b1;
            end
            st_registra: begin
                ctl.registra_jogada = 1'b1;
                ctl.sel_endereco    = 1'b1;
            end
            st_compara: begin
                ctl.habilita_comp = 1'b1;
                ctl.sel_endereco  = 1'b1;
            end
            st_avanca_espera: ctl.contaJ = 1'b1;
            st_proxima_rodada: begin
                ctl.contaL = 1'b1;
                ctl.zeraJ  = 1'b1;
                ctl.zeraP  = 1'b1;
            end
            st_ganhou: begin
                ctl.pronto = 1'b1;
                ctl.ganhou = 1'b1;
            end
            st_perdeu: begin
                ctl.pronto = 1'b1;
                ctl.perdeu = 1'b1;
            end
            st_timeout: begin
                ctl.pronto  = 1'b1;
                ctl.timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mrm_unidade_controle.sv
// tb/tb_mrm_unidade_controle.sv - random + directed self-checking bench for mrm_unidade_controle
module tb_mrm_unidade_controle;

    localparam int T = 8;

    logic clock;
    logic reset;
    mrm_unidade_controle_if ifc();

    mrm_unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
        .clock (clock),
        .reset (reset),
        .ctl   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;
    bit run_cmp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Required outputs, one line per output: the set of state codes that raise it.
    function automatic logic [16:0] exp_out(int s);
        return {s == 1 || s == 6 || s == 11,        // zeraJ
                s == 5 || s == 10,                  // contaJ
                s == 1,                             // zeraL
                s == 11,                            // contaL
                s == 1 || s == 5 || s == 6 || s == 11, // zeraP
                s == 4,                             // contaP
                s == 2,                             // gera_rand
                s == 3,                             // escreve_ram
                s == 8,                             // registra_jogada
                s == 4 || s == 8 || s == 9,         // sel_endereco
                s == 9,                             // habilita_comp
                s == 4,                             // show_display
                s == 1 || s == 6,                   // reset_display
                s >= 12 && s <= 14,                 // pronto
                s == 12, s == 13, s == 14};
    endfunction

    function automatic int model_next(int s, int waited, bit ini, bit pul, bit ig, bit fj, bit fl, bit fp);
        if (s == 0)                 return ini ? 1 : 0;
        if (s >= 12 && s <= 14)     return ini ? 1 : s;
        if (s == 4)                 return !fp ? 4 : (fj ? 6 : 5);
        if (s == 5)                 return 4;
        if (s == 7)                 return pul ? 8 : ((waited == T - 1) ? 14 : 7);
        if (s == 9)                 return !ig ? 13 : (!fj ? 10 : (!fl ? 11 : 12));
        if (s == 10)                return 7;
        if (s == 11)                return 2;
        if (s == 1 || s == 2 || s == 3 || s == 6 || s == 8) return (s == 6) ? 7 : s + 1;
        return 0;
    endfunction

    int m_state = 0;
    int m_wait  = 0;

    always @(posedge clock or negedge reset) begin
        int nxt;
        if (!reset) begin
            m_state = 0;
            m_wait  = 0;
        end else begin
            nxt = model_next(m_state, m_wait, ifc.iniciar, ifc.jogada_pulso, ifc.igual,
                             ifc.fimJ, ifc.fimL, ifc.fimP);
            m_wait  = (m_state == 7 && nxt == 7) ? m_wait + 1 : 0;
            m_state = nxt;
        end
    end

    logic [16:0] act_out;
    assign act_out = {ifc.zeraJ, ifc.contaJ, ifc.zeraL, ifc.contaL, ifc.zeraP, ifc.contaP,
                      ifc.gera_rand, ifc.escreve_ram, ifc.registra_jogada, ifc.sel_endereco,
                      ifc.habilita_comp, ifc.show_display, ifc.reset_display,
                      ifc.pronto, ifc.ganhou, ifc.perdeu, ifc.timeout};

    always @(negedge clock) begin
        if (run_cmp) begin
            chk("model_state", 32'(ifc.db_estado), 32'(m_state));
            chk("model_outs", 32'(act_out), 32'(exp_out(m_state)));
            chk("model_cnt", 32'(dut.cnt_timeout), 32'(m_wait));
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input bit ini, input bit pul, input bit ig, input bit fj, input bit fl, input bit fp);
        ifc.iniciar      = ini;
        ifc.jogada_pulso = pul;
        ifc.igual        = ig;
        ifc.fimJ         = fj;
        ifc.fimL         = fl;
        ifc.fimP         = fp;
    endtask

    // From preparacao through a one-move display into espera.
    task automatic go_espera(input string tag);
        int seq [5] = '{2, 3, 4, 6, 7};
        drive(0, 0, ifc.igual, 1, ifc.fimL, 1);
        foreach (seq[i]) begin
            step();
            chk({tag, "_to_espera"}, 32'(ifc.db_estado), 32'(seq[i]));
        end
    endtask

    initial begin
        int v2_seq [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 2};
        int n;
        vectors     = 0;
        miscompares = 0;
        run_cmp     = 0;
        reset       = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset   = 1'b1;
        run_cmp = 1;

        chk("reset_state", 32'(ifc.db_estado), 32'h0);
        chk("reset_outs", 32'(act_out), 32'h0);

        // V1: asynchronous reset while waiting for a move
        drive(1, 0, 1, 0, 0, 0);
        step();
        chk("v1_prep", 32'(ifc.db_estado), 32'h1);
        go_espera("v1");
        step();
        step();
        chk("v1_cnt_before", 32'(dut.cnt_timeout), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("v1_async_state", 32'(ifc.db_estado), 32'h0);
        chk("v1_async_outs", 32'(act_out), 32'h0);
        chk("v1_async_cnt", 32'(dut.cnt_timeout), 32'h0);
        repeat (3) begin
            @(negedge clock);
            chk("v1_hold_state", 32'(ifc.db_estado), 32'h0);
        end
        reset = 1'b1;

        // V2: one full round, correct move, round not last
        foreach (v2_seq[i]) begin
            drive(i == 0, i == 6, 1, 1, 0, 1);
            step();
            chk("v2_seq", 32'(ifc.db_estado), 32'(v2_seq[i]));
        end

        // V3: wrong move -> perdeu, held against iniciar=0 and stray pulses
        drive(0, 0, 0, 1, 0, 1);
        step();
        chk("v3_escreve", 32'(ifc.db_estado), 32'h3);
        step(); step(); step();
        chk("v3_espera", 32'(ifc.db_estado), 32'h7);
        drive(0, 1, 0, 1, 0, 1);
        step();
        drive(0, 0, 0, 1, 0, 1);
        step();
        step();
        chk("v3_perdeu_state", 32'(ifc.db_estado), 32'hD);
        repeat (3) begin
            drive(0, 1, 0, 1, 0, 1);
            step();
            chk("v3_perdeu_hold", 32'({ifc.perdeu, ifc.pronto, ifc.db_estado}), 32'h3D);
        end
        drive(1, 0, 1, 1, 0, 1);
        step();
        chk("v3_restart", 32'(ifc.db_estado), 32'h1);

        // V4: no move -> timeout exactly T cycles after entering espera
        go_espera("v4");
        drive(0, 0, 1, 1, 0, 1);
        n = 0;
        while (ifc.db_estado != 4'hE && n < 20) begin
            step();
            n++;
        end
        chk("v4_cycles", 32'(n), 32'(T));
        chk("v4_timeout_flag", 32'({ifc.timeout, ifc.pronto}), 32'h3);
        drive(1, 0, 1, 1, 0, 1);
        step();
        chk("v4_restart", 32'(ifc.db_estado), 32'h1);

        // V5: move on the expiry cycle wins
        go_espera("v5");
        drive(0, 0, 1, 1, 1, 1);
        repeat (T - 1) step();
        chk("v5_still_espera", 32'(ifc.db_estado), 32'h7);
        chk("v5_cnt_full", 32'(dut.cnt_timeout), 32'(T - 1));
        drive(0, 1, 1, 1, 1, 1);
        step();
        chk("v5_registra", 32'(ifc.db_estado), 32'h8);

        // V6: last round, correct move -> ganhou, pulses ignored there
        drive(0, 0, 1, 1, 1, 1);
        step();
        step();
        chk("v6_ganhou", 32'({ifc.ganhou, ifc.pronto, ifc.db_estado}), 32'h3C);
        drive(0, 1, 1, 1, 1, 1);
        step();
        chk("v6_pulse_ignored", 32'(ifc.db_estado), 32'hC);
        drive(1, 0, 1, 1, 1, 1);
        step();
        chk("v6_restart", 32'(ifc.db_estado), 32'h1);

        // Random phase against the model
        for (int k = 0; k < 4000; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
